// File: rtl/pwm_rampa_motor.sv
// ---------------------------------------------------------------------------
// pwm_rampa_motor
//
// Soft-start PWM driver for the motor power switch. Takes the one-hot speed
// request from the upstream selection FSM, slews an internal duty value
// toward the requested level at one percent per ramp tick, and produces a
// PWM waveform whose duty only changes on whole-period boundaries.
//
// Parameters
//   RAMP_DIV   clocks per 1 % duty step (>= 1)
//   PWM_PRESC  clocks per PWM counter increment (>= 1);
//              PWM period = 100 * PWM_PRESC clocks
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high; clears all state
//   sel_30       30 % speed request
//   sel_50       50 % speed request
//   sel_100      100 % speed request
//   pwm_out      registered motor switch drive
//   duty_actual  current ramped duty in percent, 0..100
//   ramp_state   00 PARADO, 01 SUBIENDO, 10 ESTABLE, 11 BAJANDO
//   fault        sticky: more than one sel_* was seen asserted
// ---------------------------------------------------------------------------
module pwm_rampa_motor #(
    parameter int RAMP_DIV  = 50,
    parameter int PWM_PRESC = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sel_30,
    input  logic       sel_50,
    input  logic       sel_100,
    output logic       pwm_out,
    output logic [6:0] duty_actual,
    output logic [1:0] ramp_state,
    output logic       fault
);

    // Counter widths; a divider of 1 still needs a 1-bit register.
    localparam int RW = (RAMP_DIV  > 1) ? $clog2(RAMP_DIV)  : 1;
    localparam int PW = (PWM_PRESC > 1) ? $clog2(PWM_PRESC) : 1;

    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PWM_PRESC - 1);

    localparam logic [6:0] DUTY_MAX = 7'd100;
    localparam logic [6:0] PC_LAST  = 7'd99;

    typedef enum logic [1:0] {
        PARADO   = 2'b00,
        SUBIENDO = 2'b01,
        ESTABLE  = 2'b10,
        BAJANDO  = 2'b11
    } ramp_t;

    ramp_t state, state_next;

    // -----------------------------------------------------------------------
    // Target decode
    // -----------------------------------------------------------------------
    logic [1:0] sel_cnt;
    logic       multi;
    logic [6:0] target;
    logic [6:0] target_prev;

    always_comb begin
        sel_cnt = {1'b0, sel_30} + {1'b0, sel_50} + {1'b0, sel_100};
        multi   = (sel_cnt >= 2'd2);
        target  = 7'd0;
        // An illegal code, or any earlier one, parks the target at zero so
        // the motor winds down instead of following a corrupted request.
        if (!(fault || multi)) begin
            if (sel_30)       target = 7'd30;
            else if (sel_50)  target = 7'd50;
            else if (sel_100) target = 7'd100;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) fault <= 1'b0;
        else if (multi) fault <= 1'b1;
    end

    // -----------------------------------------------------------------------
    // Ramp engine
    // -----------------------------------------------------------------------
    logic [RW-1:0] rcnt, rcnt_eff, rcnt_next;
    logic          target_chg;
    logic          ramp_tick;
    logic [6:0]    duty_next;

    always_comb begin
        target_chg = (target != target_prev);
        // A new target restarts the step interval; the edge that sees the
        // change already counts as interval clock zero, so the first step
        // lands exactly RAMP_DIV clocks later.
        rcnt_eff   = target_chg ? '0 : rcnt;
        ramp_tick  = (duty_actual != target) && (rcnt_eff == RAMP_LAST);

        duty_next = duty_actual;
        if (ramp_tick) begin
            if (duty_actual < target && duty_actual < DUTY_MAX)
                duty_next = duty_actual + 7'd1;
            else if (duty_actual > target && duty_actual != 7'd0)
                duty_next = duty_actual - 7'd1;
        end

        if (duty_actual == target || ramp_tick) rcnt_next = '0;
        else                                    rcnt_next = rcnt_eff + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcnt        <= '0;
            duty_actual <= 7'd0;
            target_prev <= 7'd0;
        end else begin
            rcnt        <= rcnt_next;
            duty_actual <= duty_next;
            target_prev <= target;
        end
    end

    // -----------------------------------------------------------------------
    // Ramp state FSM: reflects the relation between the duty being loaded
    // this edge and the live target.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= PARADO;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (duty_next < target)       state_next = SUBIENDO;
        else if (duty_next > target)  state_next = BAJANDO;
        else if (target == 7'd0)      state_next = PARADO;
        else                          state_next = ESTABLE;
    end

    assign ramp_state = state;

    // -----------------------------------------------------------------------
    // PWM generator
    // -----------------------------------------------------------------------
    logic [PW-1:0] pp;
    logic [6:0]    pc;
    logic [6:0]    duty_latched;
    logic          pc_adv;

    assign pc_adv = (pp == PRESC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pp           <= '0;
            pc           <= 7'd0;
            duty_latched <= 7'd0;
        end else begin
            pp <= pc_adv ? '0 : pp + 1'b1;
            if (pc_adv) begin
                if (pc == PC_LAST) begin
                    pc <= 7'd0;
                    // Duty only changes at the period boundary, so a ramp
                    // step never truncates or stretches a pulse.
                    duty_latched <= duty_actual;
                end else begin
                    pc <= pc + 7'd1;
                end
            end
        end
    end

    // Compare against a full 0..99 range: duty 0 never goes high and
    // duty 100 never goes low, with no single-clock slivers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pwm_out <= 1'b0;
        else       pwm_out <= (pc < duty_latched);
    end

endmodule

// File: tb/tb_pwm_rampa_motor.sv
// ---------------------------------------------------------------------------
// tb_pwm_rampa_motor
//
// Directed bench for pwm_rampa_motor with RAMP_DIV=4, PWM_PRESC=1. Inputs
// are changed and outputs sampled 1 time unit after a rising edge.
// ---------------------------------------------------------------------------
module tb_pwm_rampa_motor;

    logic       clk;
    logic       reset;
    logic       sel_30, sel_50, sel_100;
    logic       pwm_out;
    logic [6:0] duty_actual;
    logic [1:0] ramp_state;
    logic       fault;

    int checks = 0;
    int errors = 0;

    pwm_rampa_motor #(
        .RAMP_DIV (4),
        .PWM_PRESC(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sel_30     (sel_30),
        .sel_50     (sel_50),
        .sel_100    (sel_100),
        .pwm_out    (pwm_out),
        .duty_actual(duty_actual),
        .ramp_state (ramp_state),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Number of high pwm_out samples over the next n clocks.
    task automatic count_high(input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (pwm_out === 1'b1) highs++;
        end
    endtask

    int highs;

    initial begin
        reset = 1'b1; sel_30 = 1'b0; sel_50 = 1'b0; sel_100 = 1'b0;
        step(2);
        chk("rst_pwm",   pwm_out,     0);
        chk("rst_duty",  duty_actual, 0);
        chk("rst_state", ramp_state,  0);
        chk("rst_fault", fault,       0);

        // 0 -> 30
        reset = 1'b0; sel_30 = 1'b1;
        step(3);
        chk("up30_e3_duty",  duty_actual, 0);
        chk("up30_e3_state", ramp_state,  1);
        step(1);
        chk("up30_e4_duty",  duty_actual, 1);
        step(115);
        chk("up30_e119_duty",  duty_actual, 29);
        chk("up30_e119_state", ramp_state,  1);
        step(1);
        chk("up30_e120_duty",  duty_actual, 30);
        chk("up30_e120_state", ramp_state,  2);
        step(80);
        count_high(100, highs);
        chk("pwm30_highs", highs, 30);

        // 30 -> 50 -> 100
        sel_30 = 1'b0; sel_50 = 1'b1;
        step(79);
        chk("up50_e79_duty",  duty_actual, 49);
        chk("up50_e79_state", ramp_state,  1);
        step(1);
        chk("up50_e80_duty",  duty_actual, 50);
        chk("up50_e80_state", ramp_state,  2);
        sel_50 = 1'b0; sel_100 = 1'b1;
        step(199);
        chk("up100_e199_duty",  duty_actual, 99);
        chk("up100_e199_state", ramp_state,  1);
        step(1);
        chk("up100_e200_duty",  duty_actual, 100);
        chk("up100_e200_state", ramp_state,  2);
        step(150);
        count_high(100, highs);
        chk("pwm100_highs", highs, 100);

        // 100 -> 0
        sel_100 = 1'b0;
        step(1);
        chk("dn0_e1_state", ramp_state,  3);
        chk("dn0_e1_duty",  duty_actual, 100);
        step(3);
        chk("dn0_e4_duty",  duty_actual, 99);
        step(395);
        chk("dn0_e399_duty",  duty_actual, 1);
        chk("dn0_e399_state", ramp_state,  3);
        step(1);
        chk("dn0_e400_duty",  duty_actual, 0);
        chk("dn0_e400_state", ramp_state,  0);
        step(150);
        count_high(100, highs);
        chk("pwm0_highs", highs, 0);

        // Retarget mid-ramp: up toward 50, switch to 30 at duty 20
        sel_50 = 1'b1;
        step(80);
        chk("mid_e80_duty", duty_actual, 20);
        sel_50 = 1'b0; sel_30 = 1'b1;
        step(4);
        chk("mid_sw30_e4_duty", duty_actual, 21);
        step(36);
        chk("mid_sw30_e40_duty",  duty_actual, 30);
        chk("mid_sw30_e40_state", ramp_state,  2);
        sel_30 = 1'b0;
        step(120);
        chk("mid_back0_duty", duty_actual, 0);
        // Up to 25, then drop the request: reverse with no jump
        sel_50 = 1'b1;
        step(100);
        chk("rev_e100_duty",  duty_actual, 25);
        chk("rev_e100_state", ramp_state,  1);
        sel_50 = 1'b0;
        step(1);
        chk("rev_e1_duty",  duty_actual, 25);
        chk("rev_e1_state", ramp_state,  3);
        step(3);
        chk("rev_e4_duty", duty_actual, 24);
        step(96);
        chk("rev_e100_end_duty",  duty_actual, 0);
        chk("rev_e100_end_state", ramp_state,  0);

        // Fault: two selects together for one clock
        sel_30 = 1'b1;
        step(40);
        chk("flt_pre_duty",  duty_actual, 10);
        chk("flt_pre_fault", fault,       0);
        sel_100 = 1'b1;
        step(1);
        chk("flt_set_fault", fault,       1);
        chk("flt_set_state", ramp_state,  3);
        chk("flt_set_duty",  duty_actual, 10);
        sel_30 = 1'b0; sel_100 = 1'b0; sel_50 = 1'b1;
        step(3);
        chk("flt_e4_duty", duty_actual, 9);
        step(36);
        chk("flt_end_duty",  duty_actual, 0);
        chk("flt_end_state", ramp_state,  0);
        chk("flt_end_fault", fault,       1);
        step(20);
        chk("flt_hold_duty",  duty_actual, 0);
        chk("flt_hold_fault", fault,       1);

        // Reset clears fault; then asynchronous reset at duty 37
        reset = 1'b1;
        step(1);
        chk("rst2_fault", fault, 0);
        reset = 1'b0;
        step(148);
        chk("r37_duty", duty_actual, 37);
        sel_30 = 1'b1;
        step(1);
        chk("r37_fault", fault,       1);
        chk("r37_hold",  duty_actual, 37);
        #2 reset = 1'b1;
        #1;
        chk("arst_pwm",   pwm_out,     0);
        chk("arst_duty",  duty_actual, 0);
        chk("arst_fault", fault,       0);
        chk("arst_state", ramp_state,  0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
